// File: rtl/demux_stream.sv
// Registered word-stream demultiplexer: routes each accepted word to one output channel, or to
// all channels when broadcasting. Every channel has a one-entry valid/ready holding register.
module demux_stream #(
  parameter int WIDTH = 16,
  parameter int NOUT  = 3,
  parameter int SELW  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SELW-1:0]         sel,
  input  logic                    bcast,
  output logic [NOUT*WIDTH-1:0]   out_data,
  output logic [NOUT-1:0]         out_valid,
  input  logic [NOUT-1:0]         out_ready,
  output logic                    err_sel,
  output logic [7:0]              drop_cnt,
  output logic [15:0]             acc_cnt
);

  // One extra bit so that NOUT == 2**SELW is still representable.
  localparam logic [SELW:0] NOUT_W = (SELW+1)'(NOUT);

  logic [NOUT-1:0] free;
  logic [NOUT-1:0] target;
  logic [NOUT-1:0] load;
  logic            sel_oor;
  logic            accept;
  logic            drop;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    target   = '0;
    in_ready = 1'b0;
    free     = ~out_valid | out_ready;
    sel_oor  = ({1'b0, sel} >= NOUT_W);

    for (int k = 0; k < NOUT; k++) begin
      target[k] = bcast || (sel == SELW'(k));
    end

    if (bcast) begin
      in_ready = &free;
    end else if (sel_oor) begin
      in_ready = 1'b1;
    end else begin
      in_ready = |(target & free);
    end

    accept = in_valid && in_ready;
    // An out-of-range select matches no channel, so target is already all zeros for a drop.
    load   = accept ? target : '0;
    drop   = accept && !bcast && sel_oor;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the holding data registers are reset as well because they drive a visible port; pure storage would not need it.
      out_valid <= '0;
      out_data  <= '0;
      err_sel   <= 1'b0;
      drop_cnt  <= '0;
      acc_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples pre-edge values regardless of statement order.
      for (int k = 0; k < NOUT; k++) begin
        if (load[k]) begin
          out_valid[k]                <= 1'b1;
          out_data[k*WIDTH +: WIDTH]  <= in_data;
        end else if (out_valid[k] && out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end

      if (accept) begin
        acc_cnt <= acc_cnt + 16'd1;
      end

      if (drop) begin
        err_sel <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- Parametrised, registered successor to the 1-bit `_demux`: routes a WIDTH-bit word stream to one of NOUT outputs, or to all outputs in broadcast mode.
- Each output has a one-entry holding register with valid/ready flow control. Backpressure from one output stalls only words aimed at that output.
- Sits between a Hack-side word producer (memory-mapped I/O, 16-bit bus) and several peripheral sinks.

Parameters:
- WIDTH, 16, data word width in bits.
- NOUT, 3, number of output channels (1..2**SELW); not required to be a power of two.
- SELW, 2, width of sel; must satisfy 2**SELW >= NOUT.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  input word.
- in_valid  in  1  in_data/sel/bcast valid this cycle.
- in_ready  out  1  block accepts the word this cycle (combinational).
- sel  in  SELW  target channel index.
- bcast  in  1  1 = deliver word to every channel; sel ignored.
- out_data  out  NOUT*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  NOUT  channel k holding register full.
- out_ready  in  NOUT  sink k takes the word this cycle.
- err_sel  out  1  sticky: a word was dropped for sel >= NOUT.
- drop_cnt  out  8  number of dropped words, saturating at 255.
- acc_cnt  out  16  number of accepted words (including drops), wraps modulo 2**16.

Behaviour:
- Reset, sampled on a clk edge while reset=1:
  - out_valid = 0, out_data = 0, err_sel = 0, drop_cnt = 0, acc_cnt = 0.
  - reset dominates any simultaneous handshake. A word presented in a reset cycle is not accepted and not counted.
  - Mid-operation reset discards all held words.
- Per-channel free condition: free[k] = !out_valid[k] || out_ready[k]. A channel being drained this cycle may be reloaded in the same cycle.
- in_ready, combinational, selected by the first matching case:
  - bcast=1: AND of free[k] over all k.
  - sel >= NOUT: 1 (the word will be dropped).
  - otherwise: free[sel].
  - in_ready does not depend on in_valid.
- Accept = in_valid && in_ready. On accept:
  - Normal: channel sel loads in_data and sets out_valid[sel]=1. Latency is 1 cycle (the word is visible on out_data the cycle after accept).
  - Broadcast: every channel loads in_data and sets out_valid=1 in the same edge.
  - Out of range (bcast=0, sel >= NOUT): nothing is loaded; err_sel <= 1; drop_cnt increments unless it is already 255.
  - acc_cnt increments on every accept, wrapping 16'hFFFF -> 0.
- Channel k update each edge, in priority order:
  1. Load on accept if k is targeted: out_valid[k] stays 1, out_data[k] takes the new word.
  2. Else clear out_valid[k] if out_valid[k] && out_ready[k].
  3. Else hold.
- out_data[k] holds its last value after the word drains; it is not cleared.
- out_ready on an empty channel has no effect.
- Channels are independent: a full, stalled channel never blocks a word aimed at another channel.
- No combinational path from out_ready to out_data or out_valid.
- Throughput: 1 word per cycle per channel when its sink holds out_ready=1.
- in_data, sel and bcast are ignored when in_valid=0.
- err_sel clears only on reset.

Test Plan:
- Reset → all outputs zero. Then send in_data=16'h00A5, sel=1, in_valid=1 for one cycle with out_ready=3'b111 → in_ready=1; the next cycle out_valid=3'b010 and channel 1 data=00A5; one cycle later out_valid=0; acc_cnt=1.
- Backpressure:
  - Hold out_ready[0]=0; send 16'h1111 to sel=0 → accepted.
  - Send 16'h2222 to sel=0 → in_ready=0, stalled.
  - Send 16'h3333 to sel=2 the following cycle → accepted; channel 2 valid.
  - Raise out_ready[0] → 2222 loads in the same cycle that 1111 drains; channel 0 never goes empty.
- Broadcast: channel 1 full with out_ready[1]=0; present bcast=1, in_data=16'hBEEF → in_ready=0 until out_ready[1]=1. Then all three channels show BEEF with out_valid=3'b111 in the same cycle.
- Out-of-range: sel=3 with NOUT=3, three words → in_ready=1 each cycle, no out_valid change, err_sel=1, drop_cnt=3, acc_cnt=3. Repeat with 260 drops → drop_cnt saturates at 255.
- Streaming: 1000 back-to-back words to sel=2 with out_ready=1 → one word out per cycle, data order preserved, acc_cnt=1000. Continue to 65537 accepts → acc_cnt=1.
- Reset mid-operation: out_valid=3'b101 and a word presented with reset=1 → next cycle out_valid=0, counters 0, err_sel=0, word not delivered.
